mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single read/write RAM port of the unified memory between two requesters: the load/store unit (LSU) and a debug/loader port (DBG).
- The memory always writes 4 bytes at a byte address and reads combinationally. This block therefore adds sub-word store support via read-modify-write (RMW) and load sign/zero extension.
- Sits between the core LSU / debug module and the memory RAM port.

Parameters:
- STARVE_MAX, 4: consecutive denied DBG request cycles before DBG is forced to win.
- STARVE_W, 3: width of the starvation counter; must hold STARVE_MAX.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- lsu_req_i  in  1  LSU request; held stable until granted.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- lsu_unsigned_i  in  1  load zero-extend when 1, sign-extend when 0.
- lsu_addr_i  in  32  byte address.
- lsu_wdata_i  in  32  store data, right-aligned.
- lsu_gnt_o  out  1  request accepted this cycle.
- lsu_rvalid_o  out  1  load data valid / store complete.
- lsu_rdata_o  out  32  load result (0 for stores).
- dbg_req_i, dbg_we_i, dbg_addr_i[31:0], dbg_wdata_i[31:0]  in  same meaning as LSU; DBG accesses are always word accesses.
- dbg_gnt_o, dbg_rvalid_o  out  1; dbg_rdata_o  out  32.
- ram_rd_en_o  out  1; ram_rd_addr_o  out  32; ram_rd_data_i  in  32 (combinational read).
- ram_wr_en_o  out  1; ram_wr_addr_o  out  32; ram_wr_data_o  out  32.

Behaviour:
- Reset (rst_i low, async):
  - state = IDLE; starvation counter = 0.
  - All gnt, rvalid, rdata, and ram_* outputs = 0.
  - A pending RMW is discarded; no write is issued.
- States: IDLE, MERGE.
- Arbitration in IDLE is combinational from the current req inputs:
  - LSU has priority.
  - DBG wins if LSU is not requesting, or if counter == STARVE_MAX.
  - At most one gnt per cycle; no gnt is issued while in MERGE.
- Starvation counter:
  - Increments each cycle dbg_req_i=1 and dbg_gnt_o=0, saturating at STARVE_MAX.
  - Clears on dbg_gnt_o.
  - Holds when dbg_req_i=0.
- Load (granted in IDLE):
  - ram_rd_en_o=1 and ram_rd_addr_o=addr in the grant cycle.
  - ram_rd_data_i is extended per size/unsigned and registered.
  - rvalid is asserted the next cycle for one cycle. Latency is 1.
- Word store (granted in IDLE):
  - ram_wr_en_o=1 with addr/wdata in the grant cycle; the memory commits at the posedge.
  - rvalid (ack) the next cycle. Latency is 1.
- Sub-word store (LSU byte/half):
  - Grant cycle: read the word at addr; register the merged word (low 8 or 16 bits replaced by wdata, upper bytes kept); go to MERGE.
  - MERGE: ram_wr_en_o=1 at the registered addr with the merged data; return to IDLE.
  - rvalid the cycle after MERGE. Latency is 2.
- Requests arriving during MERGE wait; requesters hold req until gnt.
- A back-to-back load immediately after a store reads the updated data. The memory write completes before the next-cycle read.
- No alignment checks; misaligned addresses pass through. The memory is byte addressed.
- rvalid goes only to the requester that was granted; the other requester's rdata stays 0.

Decomposition:
- Package mem_arb_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encodings ST_IDLE, ST_MERGE.
  - Requester IDs REQ_LSU, REQ_DBG.
- One combinational sub-module, mem_byte_lane: load extension (size, unsigned) and store merge (old word, new data, size).

Test Plan:
- LSU word store 0xDEADBEEF to 0x200010, then a word load from 0x200010 → gnt same cycle; rvalid +1 each; load rdata=0xDEADBEEF.
- LSU byte store 0x5A to 0x200010 over 0xDEADBEEF → ram_rd_en in grant cycle, ram_wr_data=0xDEADBE5A in the MERGE cycle, rvalid 2 cycles after gnt.
- Loads of byte 0x80 and half 0x8001 at the base of a word whose upper bytes are nonzero:
  - Byte, signed → 0xFFFFFF80; byte, unsigned → 0x00000080.
  - Half, signed → 0xFFFF8001; half, unsigned → 0x00008001.
- LSU and DBG both requesting continuously with STARVE_MAX=4 → LSU granted 4 cycles, DBG granted on the 5th, counter cleared, pattern repeats.
- DBG request arriving in a MERGE cycle → dbg_gnt_o=0 that cycle, granted the following cycle.
- rst_i driven low during MERGE → all outputs 0 immediately; no ram_wr_en_o pulse; state IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: access sizes, FSM states, requester IDs.
// Also a small helper to classify sub-word accesses that need read-modify-write.
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    // Size 2'b11 is handled as a word access, so only byte/half are sub-word.
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the LSU, debug and RAM-port signals of the memory port arbiter.
// slave = arbiter view, master = view of the surrounding core/debug/RAM.
interface mem_port_arbiter_if;

    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_gnt_o;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;

    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [31:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;

    logic        ram_rd_en_o;
    logic [31:0] ram_rd_addr_o;
    logic [31:0] ram_rd_data_i;
    logic        ram_wr_en_o;
    logic [31:0] ram_wr_addr_o;
    logic [31:0] ram_wr_data_o;

    modport slave (
        input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output ram_rd_en_o, ram_rd_addr_o,
        input  ram_rd_data_i,
        output ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o
    );

    modport master (
        output lsu_req_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  ram_rd_en_o, ram_rd_addr_o,
        output ram_rd_data_i,
        input  ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o
    );

endinterface

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane logic: load sign/zero extension and sub-word store merge.
// Operates on the low byte/half of the word; the RAM already returns the addressed byte in [7:0].
module mem_byte_lane
    import mem_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    always_comb begin
        ld_data = rd_word;
        st_data = wdata;
        case (size)
            SZ_BYTE: begin
                ld_data = unsigned_ld ? {24'h0, rd_word[7:0]}
                                      : {{24{rd_word[7]}}, rd_word[7:0]};
                st_data = {rd_word[31:8], wdata[7:0]};
            end
            SZ_HALF: begin
                ld_data = unsigned_ld ? {16'h0, rd_word[15:0]}
                                      : {{16{rd_word[15]}}, rd_word[15:0]};
                st_data = {rd_word[31:16], wdata[15:0]};
            end
            default: begin
                ld_data = rd_word;
                st_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between LSU and debug; LSU priority with debug anti-starvation.
// Loads/word stores respond after 1 cycle, sub-word stores (read-modify-write) after 2.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int STARVE_W   = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_port_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_e               state_q, state_d;
    logic [STARVE_W-1:0]  starve_q;
    logic [31:0]          merge_addr_q;
    logic [31:0]          merge_dat_q;
    logic                 merge_load;

    logic                 rsp_vld_q, rsp_vld_d;
    req_id_e              rsp_id_q, rsp_id_d;
    logic [31:0]          rsp_dat_q, rsp_dat_d;

    logic                 lsu_win, dbg_win;
    logic                 lsu_gnt, dbg_gnt;
    logic                 rd_en, wr_en;
    logic [31:0]          rd_addr, wr_addr, wr_data;
    logic [31:0]          ld_ext, st_merged;

    mem_byte_lane u_lane (
        .size        (bus.lsu_size_i),
        .unsigned_ld (bus.lsu_unsigned_i),
        .rd_word     (bus.ram_rd_data_i),
        .wdata       (bus.lsu_wdata_i),
        .ld_data     (ld_ext),
        .st_data     (st_merged)
    );

    assign dbg_win = bus.dbg_req_i && (!bus.lsu_req_i || (starve_q == STARVE_LIM));
    assign lsu_win = bus.lsu_req_i && !dbg_win;

    // Everything visible is gated by rst_i so outputs drop the instant reset asserts.
    always_comb begin
        state_d    = state_q;
        rsp_vld_d  = 1'b0;
        rsp_id_d   = rsp_id_q;
        rsp_dat_d  = '0;
        merge_load = 1'b0;
        lsu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        if (rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (lsu_win) begin
                        lsu_gnt   = 1'b1;
                        rsp_id_d  = REQ_LSU;
                        rsp_vld_d = 1'b1;
                        if (!bus.lsu_we_i) begin
                            rd_en     = 1'b1;
                            rd_addr   = bus.lsu_addr_i;
                            rsp_dat_d = ld_ext;
                        end else if (is_subword(bus.lsu_size_i)) begin
                            // Response is deferred until the merged word is written.
                            rd_en      = 1'b1;
                            rd_addr    = bus.lsu_addr_i;
                            merge_load = 1'b1;
                            rsp_vld_d  = 1'b0;
                            state_d    = ST_MERGE;
                        end else begin
                            wr_en   = 1'b1;
                            wr_addr = bus.lsu_addr_i;
                            wr_data = bus.lsu_wdata_i;
                        end
                    end else if (dbg_win) begin
                        dbg_gnt   = 1'b1;
                        rsp_id_d  = REQ_DBG;
                        rsp_vld_d = 1'b1;
                        if (!bus.dbg_we_i) begin
                            rd_en     = 1'b1;
                            rd_addr   = bus.dbg_addr_i;
                            rsp_dat_d = bus.ram_rd_data_i;
                        end else begin
                            wr_en   = 1'b1;
                            wr_addr = bus.dbg_addr_i;
                            wr_data = bus.dbg_wdata_i;
                        end
                    end
                end
                ST_MERGE: begin
                    wr_en     = 1'b1;
                    wr_addr   = merge_addr_q;
                    wr_data   = merge_dat_q;
                    rsp_id_d  = REQ_LSU;
                    rsp_vld_d = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            merge_addr_q <= '0;
            merge_dat_q  <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_id_q     <= REQ_LSU;
            rsp_dat_q    <= '0;
        end else begin
            state_q   <= state_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_dat_q <= rsp_dat_d;
            if (merge_load) begin
                merge_addr_q <= bus.lsu_addr_i;
                merge_dat_q  <= st_merged;
            end
            if (dbg_gnt) begin
                starve_q <= '0;
            end else if (bus.dbg_req_i && (starve_q != STARVE_LIM)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

    assign bus.lsu_gnt_o     = lsu_gnt;
    assign bus.dbg_gnt_o     = dbg_gnt;
    assign bus.lsu_rvalid_o  = rsp_vld_q && (rsp_id_q == REQ_LSU);
    assign bus.dbg_rvalid_o  = rsp_vld_q && (rsp_id_q == REQ_DBG);
    assign bus.lsu_rdata_o   = bus.lsu_rvalid_o ? rsp_dat_q : 32'h0;
    assign bus.dbg_rdata_o   = bus.dbg_rvalid_o ? rsp_dat_q : 32'h0;
    assign bus.ram_rd_en_o   = rd_en;
    assign bus.ram_rd_addr_o = rd_addr;
    assign bus.ram_wr_en_o   = wr_en;
    assign bus.ram_wr_addr_o = wr_addr;
    assign bus.ram_wr_data_o = wr_data;

    a_one_gnt: assert property (@(posedge clk_i) disable iff (!rst_i) !(lsu_gnt && dbg_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: LSU vector table with latency checks, rdata scoreboards,
// plus hand sequences for merge/debug overlap, starvation and reset during merge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if mif ();

    mem_port_arbiter #(.STARVE_MAX(4), .STARVE_W(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (mif)
    );

    // Byte-addressed RAM model, 256 bytes, indexed by the low address byte.
    logic [7:0] mem [0:255];
    logic [7:0] ra0, ra1, ra2, ra3, wa0, wa1, wa2, wa3;
    assign ra0 = mif.ram_rd_addr_o[7:0];
    assign ra1 = ra0 + 8'd1;
    assign ra2 = ra0 + 8'd2;
    assign ra3 = ra0 + 8'd3;
    assign wa0 = mif.ram_wr_addr_o[7:0];
    assign wa1 = wa0 + 8'd1;
    assign wa2 = wa0 + 8'd2;
    assign wa3 = wa0 + 8'd3;
    assign mif.ram_rd_data_i = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};

    always @(posedge clk) begin
        if (mif.ram_wr_en_o) begin
            mem[wa0] <= mif.ram_wr_data_o[7:0];
            mem[wa1] <= mif.ram_wr_data_o[15:8];
            mem[wa2] <= mif.ram_wr_data_o[23:16];
            mem[wa3] <= mif.ram_wr_data_o[31:24];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] lsu_q[$];
    logic [31:0] dbg_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitors: pop the scoreboard whenever the DUT signals rvalid.
    always @(negedge clk) begin
        if (mif.lsu_rvalid_o) begin
            if (lsu_q.size() == 0) check("lsu_unexpected_rvalid", 32'd1, 32'd0);
            else check("lsu_rdata", mif.lsu_rdata_o, lsu_q.pop_front());
            if (!mif.dbg_rvalid_o) check("dbg_rdata_quiet", mif.dbg_rdata_o, 32'h0);
        end
        if (mif.dbg_rvalid_o) begin
            if (dbg_q.size() == 0) check("dbg_unexpected_rvalid", 32'd1, 32'd0);
            else check("dbg_rdata", mif.dbg_rdata_o, dbg_q.pop_front());
            if (!mif.lsu_rvalid_o) check("lsu_rdata_quiet", mif.lsu_rdata_o, 32'h0);
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic lsu_set(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        mif.lsu_req_i      = 1'b1;
        mif.lsu_we_i       = we;
        mif.lsu_size_i     = size;
        mif.lsu_unsigned_i = uns;
        mif.lsu_addr_i     = addr;
        mif.lsu_wdata_i    = wdata;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic lsu_op(input vec_t v);
        bit got = 0;
        int lat = 0;
        lsu_set(v.we, v.size, v.uns, v.addr, v.wdata);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mif.lsu_gnt_o) begin got = 1; break; end
        end
        check("lsu_gnt", {31'h0, got}, 32'd1);
        if (got) lsu_q.push_back(v.rdata);
        @(posedge clk); #1;
        mif.lsu_req_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (mif.lsu_rvalid_o) begin lat = i; break; end
        end
        check("lsu_latency", lat, v.lat);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h0020_0010, 32'hDEADBEEF, 32'h0,        1};
        vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h0020_0010, 32'h0,        32'hDEADBEEF, 1};
        vecs[2]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0020_0010, 32'hFFFFFF5A, 32'h0,        2};
        vecs[3]  = '{1'b0, SZ_WORD, 1'b0, 32'h0020_0010, 32'h0,        32'hDEADBE5A, 1};
        vecs[4]  = '{1'b1, SZ_WORD, 1'b0, 32'h0020_0020, 32'h55AA8001, 32'h0,        1};
        vecs[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h0020_0020, 32'h0,        32'hFFFF8001, 1};
        vecs[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h0020_0020, 32'h0,        32'h00008001, 1};
        vecs[7]  = '{1'b1, SZ_WORD, 1'b0, 32'h0020_0030, 32'h55AA0180, 32'h0,        1};
        vecs[8]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0020_0030, 32'h0,        32'hFFFFFF80, 1};
        vecs[9]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0020_0030, 32'h0,        32'h00000080, 1};
        vecs[10] = '{1'b1, SZ_HALF, 1'b0, 32'h0020_0020, 32'h1234BEEF, 32'h0,        2};
        vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h0020_0020, 32'h0,        32'h55AABEEF, 1};
        vecs[12] = '{1'b0, 2'b11,   1'b0, 32'h0020_0010, 32'h0,        32'hDEADBE5A, 1};
        vecs[13] = '{1'b0, SZ_BYTE, 1'b1, 32'h0020_0031, 32'h0,        32'h00000001, 1};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        lsu_set(1'b1, SZ_WORD, 1'b0, 32'h0020_0010, 32'h12345678);
        mif.dbg_req_i   = 1'b1;
        mif.dbg_we_i    = 1'b1;
        mif.dbg_addr_i  = 32'h0020_0010;
        mif.dbg_wdata_i = 32'h87654321;

        // Reset state with both requesters active.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_lsu_gnt", {31'h0, mif.lsu_gnt_o}, 32'd0);
        check("rst_dbg_gnt", {31'h0, mif.dbg_gnt_o}, 32'd0);
        check("rst_rvalid", {30'h0, mif.lsu_rvalid_o, mif.dbg_rvalid_o}, 32'd0);
        check("rst_rdata", mif.lsu_rdata_o | mif.dbg_rdata_o, 32'h0);
        check("rst_ram_en", {30'h0, mif.ram_rd_en_o, mif.ram_wr_en_o}, 32'd0);
        check("rst_ram_bus", mif.ram_rd_addr_o | mif.ram_wr_addr_o | mif.ram_wr_data_o, 32'h0);
        mif.lsu_req_i = 1'b0;
        mif.dbg_req_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) lsu_op(vecs[i]);

        // Sub-word store with a debug load arriving during MERGE.
        lsu_op('{1'b1, SZ_WORD, 1'b0, 32'h0020_0040, 32'h11223344, 32'h0, 1});
        lsu_set(1'b1, SZ_BYTE, 1'b0, 32'h0020_0040, 32'h00000077);
        @(negedge clk);
        check("rmw_gnt", {31'h0, mif.lsu_gnt_o}, 32'd1);
        check("rmw_rd_en", {31'h0, mif.ram_rd_en_o}, 32'd1);
        check("rmw_rd_addr", mif.ram_rd_addr_o, 32'h0020_0040);
        check("rmw_no_wr", {31'h0, mif.ram_wr_en_o}, 32'd0);
        if (mif.lsu_gnt_o) lsu_q.push_back(32'h0);
        @(posedge clk); #1;
        mif.lsu_req_i  = 1'b0;
        mif.dbg_req_i  = 1'b1;
        mif.dbg_we_i   = 1'b0;
        mif.dbg_addr_i = 32'h0020_0040;
        @(negedge clk);
        check("merge_dbg_gnt", {31'h0, mif.dbg_gnt_o}, 32'd0);
        check("merge_wr_en", {31'h0, mif.ram_wr_en_o}, 32'd1);
        check("merge_wr_addr", mif.ram_wr_addr_o, 32'h0020_0040);
        check("merge_wr_data", mif.ram_wr_data_o, 32'h11223377);
        check("merge_no_rvalid", {31'h0, mif.lsu_rvalid_o}, 32'd0);
        @(negedge clk);
        check("post_merge_dbg_gnt", {31'h0, mif.dbg_gnt_o}, 32'd1);
        check("post_merge_lsu_rvalid", {31'h0, mif.lsu_rvalid_o}, 32'd1);
        if (mif.dbg_gnt_o) dbg_q.push_back(32'h11223377);
        @(posedge clk); #1;
        mif.dbg_req_i = 1'b0;
        @(negedge clk);
        check("dbg_rvalid", {31'h0, mif.dbg_rvalid_o}, 32'd1);
        @(posedge clk); #1;

        // Both requesting continuously: DBG must win every fifth cycle.
        lsu_set(1'b0, SZ_WORD, 1'b0, 32'h0020_0010, 32'h0);
        mif.dbg_req_i  = 1'b1;
        mif.dbg_we_i   = 1'b0;
        mif.dbg_addr_i = 32'h0020_0040;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("starve_dbg_gnt", {31'h0, mif.dbg_gnt_o}, {31'h0, (i % 5) == 4});
            check("starve_lsu_gnt", {31'h0, mif.lsu_gnt_o}, {31'h0, (i % 5) != 4});
            if (mif.lsu_gnt_o) lsu_q.push_back(32'hDEADBE5A);
            if (mif.dbg_gnt_o) dbg_q.push_back(32'h11223377);
            @(posedge clk);
        end
        #1;
        mif.lsu_req_i = 1'b0;
        mif.dbg_req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted while in MERGE: no write, outputs drop at once.
        lsu_op('{1'b1, SZ_WORD, 1'b0, 32'h0020_0050, 32'hCAFEF00D, 32'h0, 1});
        lsu_set(1'b1, SZ_BYTE, 1'b0, 32'h0020_0050, 32'h00000011);
        @(negedge clk);
        check("rstm_gnt", {31'h0, mif.lsu_gnt_o}, 32'd1);
        @(posedge clk); #1;
        mif.lsu_req_i = 1'b0;
        check("rstm_in_merge_wr", {31'h0, mif.ram_wr_en_o}, 32'd1);
        rst = 1'b0;
        #1;
        check("rstm_wr_en", {31'h0, mif.ram_wr_en_o}, 32'd0);
        check("rstm_wr_bus", mif.ram_wr_addr_o | mif.ram_wr_data_o, 32'h0);
        check("rstm_rvalid", {30'h0, mif.lsu_rvalid_o, mif.dbg_rvalid_o}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstm_held_rvalid", {31'h0, mif.lsu_rvalid_o}, 32'd0);
        rst = 1'b1;
        lsu_q.delete();
        @(posedge clk); #1;
        lsu_op('{1'b0, SZ_WORD, 1'b0, 32'h0020_0050, 32'h0, 32'hCAFEF00D, 1});

        repeat (2) @(posedge clk);
        check("lsu_q_drained", lsu_q.size(), 32'd0);
        check("dbg_q_drained", dbg_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
